uart_cmd_parser: RTL and testbench

- Consumes the received-byte stream from the UART receiver stage and parses ASCII line commands of the form "Waaddd<EOL>".
- Each valid line produces one 16-bit WM8731 control word {addr[6:0], data[8:0]}. The word goes to the downstream codec-configuration master over a valid/ready handshake.
- Malformed, out-of-range and stalled lines are rejected with an error code.

---
 rtl/uart_cmd_parser_pkg.sv | 36 +++
 rtl/uart_cmd_parser_hex_ascii_decode.sv | 22 ++
 rtl/uart_cmd_parser.sv | 206 ++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants, FSM state type and small helpers for the UART command
// parser slice (package uart_cmd_pkg).
package uart_cmd_pkg;

  // ASCII characters recognised or emitted by the parser
  localparam logic [7:0] CH_W    = 8'h57;  // 'W'
  localparam logic [7:0] CH_W_LC = 8'h77;  // 'w'
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_ACK  = 8'h4B;  // 'K'
  localparam logic [7:0] CH_NAK  = 8'h45;  // 'E'

  // err_code values
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CHAR    = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Line parser states: one state per expected character of "Waaddd<EOL>"
  typedef enum logic [3:0] {
    IDLE,
    A1,
    A0,
    D2,
    D1,
    D0,
    EOL,
    ISSUE,
    DISCARD
  } state_t;

  function automatic logic is_eol(input logic [7:0] ch);
    return (ch == CH_CR) || (ch == CH_LF);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_hex_ascii_decode.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f'.
module hex_ascii_decode (
  input  logic [7:0] ch,
  output logic       is_hex,
  output logic [3:0] nibble
);

  // Map a character to its nibble value and flag whether it is a hex digit
  always_comb begin
    is_hex = 1'b0;
    nibble = '0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_hex = 1'b1;
      nibble = ch[3:0];
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
      is_hex = 1'b1;
      nibble = ch[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART line-command parser: turns "Waaddd<EOL>" lines into WM8731 control
// words {addr[6:0], data[8:0]} on a valid/ready interface, rejecting
// malformed, out-of-range and stalled lines with an error code.
// Optional macro UART_CMD_ACK_EN adds a one-entry 'K'/'E' response channel
// towards the UART transmitter.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] cmd_word,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic        ovf,
  output logic        busy
`ifdef UART_CMD_ACK_EN
  ,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`endif
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_hex;
  logic [3:0]    nib;
  logic          in_line;
  logic          timeout;
  logic [1:0]    err_kind;
  logic          err_set;
  logic          load_word;
  logic          handshake;
  logic          rx_ovf;
  logic          ovf_set;

  logic [2:0]    addr_hi_q;
  logic [3:0]    addr_lo_q;
  logic          d2_q;
  logic [3:0]    d1_q;
  logic [3:0]    d0_q;

  hex_ascii_decode u_hex (
    .ch     (rx_data),
    .is_hex (is_hex),
    .nibble (nib)
  );

  assign in_line = (state_q == A1) || (state_q == A0) || (state_q == D2) ||
                   (state_q == D1) || (state_q == D0) || (state_q == EOL);
  assign busy    = (state_q != IDLE);

  // Next-state, error classification and inter-byte timeout detection
  always_comb begin
    state_d   = state_q;
    err_kind  = ERR_NONE;
    load_word = 1'b0;
    handshake = 1'b0;
    rx_ovf    = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      IDLE: if (rx_valid) begin
        if (rx_data == CH_W || rx_data == CH_W_LC) state_d = A1;
        else if (!is_eol(rx_data))                 err_kind = ERR_CHAR;
      end
      A1: if (rx_valid) begin
        if (!is_hex)       err_kind = ERR_CHAR;
        else if (nib[3])   err_kind = ERR_RANGE;
        else               state_d = A0;
      end
      A0: if (rx_valid) begin
        if (!is_hex) err_kind = ERR_CHAR;
        else         state_d = D2;
      end
      D2: if (rx_valid) begin
        if (!is_hex)            err_kind = ERR_CHAR;
        else if (nib[3:1] != 0) err_kind = ERR_RANGE;
        else                    state_d = D1;
      end
      D1: if (rx_valid) begin
        if (!is_hex) err_kind = ERR_CHAR;
        else         state_d = D0;
      end
      D0: if (rx_valid) begin
        if (!is_hex) err_kind = ERR_CHAR;
        else         state_d = EOL;
      end
      EOL: if (rx_valid) begin
        if (is_eol(rx_data)) begin
          state_d   = ISSUE;
          load_word = 1'b1;
        end else begin
          err_kind = ERR_CHAR;
        end
      end
      ISSUE: begin
        rx_ovf = rx_valid;
        if (cmd_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      DISCARD: if (rx_valid && is_eol(rx_data)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A byte arriving in the expiry cycle suppresses the timeout
    if (in_line && !rx_valid && cnt_q == CNT_LAST) begin
      timeout  = 1'b1;
      err_kind = ERR_TIMEOUT;
      state_d  = IDLE;
    end else if (err_kind != ERR_NONE) begin
      state_d = DISCARD;
    end

    err_set = (err_kind != ERR_NONE);
    cnt_d   = (in_line && !rx_valid && !timeout) ? cnt_q + CW'(1) : '0;
  end

  // State, timeout counter and command/error output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_word  <= '0;
      cmd_valid <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_pulse <= err_set;
      if (err_set) err_code <= err_kind;
      if (load_word) begin
        cmd_word  <= {addr_hi_q, addr_lo_q, d2_q, d1_q, d0_q};
        cmd_valid <= 1'b1;
      end else if (handshake) begin
        cmd_valid <= 1'b0;
      end
    end
  end

  // Capture each hex field as its character is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hi_q <= '0;
      addr_lo_q <= '0;
      d2_q      <= 1'b0;
      d1_q      <= '0;
      d0_q      <= '0;
    end else if (rx_valid && is_hex) begin
      unique case (state_q)
        A1:      addr_hi_q <= nib[2:0];
        A0:      addr_lo_q <= nib;
        D2:      d2_q      <= nib[0];
        D1:      d1_q      <= nib;
        D0:      d0_q      <= nib;
        default: ;
      endcase
    end
  end

`ifdef UART_CMD_ACK_EN
  logic       tx_push;
  logic       tx_drop;
  logic [7:0] tx_char;

  assign tx_push = handshake || err_set;
  assign tx_char = handshake ? CH_ACK : CH_NAK;
  // A response is lost only if the register is full and not draining this cycle
  assign tx_drop = tx_push && tx_valid && !tx_ready;
  assign ovf_set = rx_ovf || tx_drop;

  // One-entry response holding register towards the UART transmitter
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      if (tx_push && (!tx_valid || tx_ready)) begin
        tx_valid <= 1'b1;
        tx_data  <= tx_char;
      end
    end
  end
`else
  assign ovf_set = rx_ovf;
`endif

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser; expected command words are queued
// as lines are sent and compared when the DUT presents them. Build with
// UART_CMD_ACK_EN defined to also exercise the response channel.
module tb_uart_cmd_parser;

  localparam int unsigned TP = 64;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] cmd_word;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic        ovf;
  logic        busy;
`ifdef UART_CMD_ACK_EN
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_hs     = 0;
  int unsigned n_err    = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [7:0]  tx_q[$];

  uart_cmd_parser #(.TIMEOUT_CYCLES(TP)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cmd_word  (cmd_word),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .ovf       (ovf),
    .busy      (busy)
`ifdef UART_CMD_ACK_EN
    ,
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe handshakes and error pulses mid-cycle, away from the clock edge
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      n_hs++;
      got_q.push_back(cmd_word);
    end
    if (err_pulse) n_err++;
`ifdef UART_CMD_ACK_EN
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
`endif
  end

  function automatic logic [15:0] mk_word(input logic [6:0] a, input logic [8:0] d);
    return {a, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_line(input string s);
    send_str(s);
    send_byte(8'h0A);
  endtask

  // Wait (bounded) for a command, compare against the scoreboard, then accept it
  task automatic wait_cmd(input string name);
    logic [15:0] exp;
    int unsigned n;
    n = 0;
    while (!cmd_valid && n < 32) begin
      step();
      n++;
    end
    n_checks++;
    if (cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_valid: cmd_valid=%b after %0d cycles, required 1", name, cmd_valid, n);
    end else begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s_unexpected: cmd_word=%h presented, no command expected", name, cmd_word);
      end else begin
        exp = exp_q.pop_front();
        if (cmd_word !== exp) begin
          n_fail++;
          $display("FAIL %s_word: cmd_word=%h, required %h", name, cmd_word, exp);
        end
      end
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      n_checks++;
      if (cmd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_drop: cmd_valid=%b after handshake, required 0", name, cmd_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({cmd_word, cmd_valid, err_pulse, err_code, ovf, busy} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: word=%h v=%b ep=%b ec=%0d ovf=%b busy=%b, required all 0",
               cmd_word, cmd_valid, err_pulse, err_code, ovf, busy);
    end
`ifdef UART_CMD_ACK_EN
    n_checks++;
    if ({tx_valid, tx_data} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_tx: tx_valid=%b tx_data=%h, required 0", tx_valid, tx_data);
    end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int unsigned e0, h0;
    e0 = n_err;
    h0 = n_hs;
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h0A);
    n_checks++;
    if (busy !== 1'b0 || n_err != e0) begin
      n_fail++;
      $display("FAIL idle_eol: busy=%b errs=%0d, required busy 0 errs %0d", busy, n_err - e0, 0);
    end
    exp_q.push_back(mk_word(7'h04, 9'h079));
    send_line("W04079");
    wait_cmd("basic");
    exp_q.push_back(mk_word(7'h7F, 9'h1FF));
    send_line("W7F1FF");
    wait_cmd("max_fields");
    exp_q.push_back(mk_word(7'h7A, 9'h1BC));
    send_line("w7a1Bc");
    wait_cmd("lower_hex");
    n_checks++;
    if (n_err != e0) begin
      n_fail++;
      $display("FAIL basic_no_err: %0d error pulses, required 0", n_err - e0);
    end
    n_checks++;
    if (n_hs != h0 + 3) begin
      n_fail++;
      $display("FAIL basic_hs: %0d handshakes, required 3", n_hs - h0);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned h0;
    logic [15:0] w1, w2;
    h0 = n_hs;
    got_q.delete();
    w1 = mk_word(7'h1A, 9'h0C3);
    w2 = mk_word(7'h2B, 9'h155);
    exp_q.push_back(w1);
    exp_q.push_back(w2);
    cmd_ready = 1'b1;
    send_line("W1A0C3");
    step();
    send_line("W2B155");
    step();
    step();
    cmd_ready = 1'b0;
    n_checks++;
    if (n_hs != h0 + 2 || got_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: %0d handshakes, %0d words, required 2", n_hs - h0, got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[0]) begin
          n_fail++;
          $display("FAIL b2b_word%0d: cmd_word=%h, required %h", i, got_q[i], exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    exp_q.delete();
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ovf: ovf=%b, required 0", ovf);
    end
  endtask

  task automatic test_errors();
    int unsigned e0, h0;
    e0 = n_err;
    h0 = n_hs;
    send_str("W8");
    n_checks++;
    if (err_pulse !== 1'b1 || err_code !== 2'd2) begin
      n_fail++;
      $display("FAIL range_a1: err_pulse=%b err_code=%0d, required 1 and 2", err_pulse, err_code);
    end
    step();
    n_checks++;
    if (err_pulse !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pulse_width: err_pulse=%b busy=%b, required 0 and 1", err_pulse, busy);
    end
    send_line("0000");
    n_checks++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL discard_exit: busy=%b cmd_valid=%b, required 0 and 0", busy, cmd_valid);
    end
    send_str("W0G");
    n_checks++;
    if (err_pulse !== 1'b1 || err_code !== 2'd1) begin
      n_fail++;
      $display("FAIL bad_char: err_pulse=%b err_code=%0d, required 1 and 1", err_pulse, err_code);
    end
    send_byte(8'h0A);
    send_str("W002");
    n_checks++;
    if (err_pulse !== 1'b1 || err_code !== 2'd2) begin
      n_fail++;
      $display("FAIL range_d2: err_pulse=%b err_code=%0d, required 1 and 2", err_pulse, err_code);
    end
    send_byte(8'h0D);
    send_str("W04079X");
    n_checks++;
    if (err_pulse !== 1'b1 || err_code !== 2'd1) begin
      n_fail++;
      $display("FAIL eol_char: err_pulse=%b err_code=%0d, required 1 and 1", err_pulse, err_code);
    end
    send_byte(8'h0A);
    send_str("Q");
    send_byte(8'h0A);
    n_checks++;
    if (n_err != e0 + 5 || n_hs != h0 || cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_totals: %0d errs %0d hs cmd_valid=%b, required 5, 0, 0",
               n_err - e0, n_hs - h0, cmd_valid);
    end
    exp_q.push_back(mk_word(7'h04, 9'h079));
    send_line("w04079");
    wait_cmd("after_err");
    n_checks++;
    if (err_code !== 2'd1) begin
      n_fail++;
      $display("FAIL err_hold: err_code=%0d, required 1", err_code);
    end
  endtask

  task automatic test_timeout();
    int unsigned e0, n;
    bit hit;
    e0  = n_err;
    n   = 0;
    hit = 1'b0;
    send_str("W04");
    while (n < TP + 8 && !hit) begin
      step();
      n++;
      if (err_pulse) hit = 1'b1;
    end
    n_checks++;
    if (!hit || n != TP) begin
      n_fail++;
      $display("FAIL timeout_latency: pulse seen=%0b after %0d cycles, required %0d", hit, n, TP);
    end
    n_checks++;
    if (err_code !== 2'd3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_code: err_code=%0d busy=%b, required 3 and 0", err_code, busy);
    end
    step();
    n_checks++;
    if (err_pulse !== 1'b0 || busy !== 1'b0 || n_err != e0 + 1) begin
      n_fail++;
      $display("FAIL timeout_after: err_pulse=%b busy=%b errs=%0d, required 0 0 1",
               err_pulse, busy, n_err - e0);
    end
    // Byte lands exactly in the expiry cycle: it must be taken, no timeout
    e0 = n_err;
    exp_q.push_back(mk_word(7'h04, 9'h079));
    send_str("W0");
    repeat (TP - 1) step();
    send_str("4079");
    n_checks++;
    if (n_err != e0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL expiry_race: errs=%0d busy=%b, required 0 and 1", n_err - e0, busy);
    end
    send_byte(8'h0A);
    wait_cmd("expiry_race");
  endtask

  task automatic test_hold();
    int unsigned h0;
    logic [15:0] w;
    h0 = n_hs;
    w  = mk_word(7'h0F, 9'h000);
    exp_q.push_back(w);
    send_str("W0F000");
    send_byte(8'h0D);
    n_checks++;
    if (cmd_valid !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_start: cmd_valid=%b ovf=%b, required 1 and 0", cmd_valid, ovf);
    end
    send_byte(8'h0A);
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_ovf: ovf=%b, required 1", ovf);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_word !== w) begin
        n_fail++;
        $display("FAIL hold_stable%0d: cmd_valid=%b cmd_word=%h, required 1 and %h", i, cmd_valid, cmd_word, w);
      end
    end
    wait_cmd("hold");
    repeat (3) step();
    n_checks++;
    if (n_hs != h0 + 1) begin
      n_fail++;
      $display("FAIL hold_hs: %0d handshakes, required 1", n_hs - h0);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned h0;
    send_str("W040");
    rst = 1'b1;
    step();
    n_checks++;
    if ({cmd_word, cmd_valid, err_pulse, err_code, ovf, busy} !== 22'd0) begin
      n_fail++;
      $display("FAIL midline_reset: word=%h v=%b ep=%b ec=%0d ovf=%b busy=%b, required all 0",
               cmd_word, cmd_valid, err_pulse, err_code, ovf, busy);
    end
    rst = 1'b0;
    step();
    h0 = n_hs;
    send_line("W12034");
    n_checks++;
    if (cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_pre_reset: cmd_valid=%b, required 1", cmd_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmd_ready = 1'b1;
    repeat (5) step();
    cmd_ready = 1'b0;
    n_checks++;
    if (cmd_valid !== 1'b0 || n_hs != h0 || cmd_word !== 16'd0) begin
      n_fail++;
      $display("FAIL issue_reset: cmd_valid=%b hs=%0d word=%h, required 0 0 0000",
               cmd_valid, n_hs - h0, cmd_word);
    end
    exp_q.push_back(mk_word(7'h04, 9'h079));
    send_line("W04079");
    wait_cmd("post_reset");
    n_checks++;
    if (n_hs != h0 + 1) begin
      n_fail++;
      $display("FAIL post_reset_hs: %0d handshakes, required 1", n_hs - h0);
    end
  endtask

`ifdef UART_CMD_ACK_EN
  task automatic test_ack();
    test_reset();
    tx_ready = 1'b1;
    tx_q.delete();
    exp_q.push_back(mk_word(7'h04, 9'h079));
    send_line("W04079");
    wait_cmd("ack_good");
    send_line("WX");
    repeat (3) step();
    n_checks++;
    if (tx_q.size() != 2) begin
      n_fail++;
      $display("FAIL ack_count: %0d responses, required 2", tx_q.size());
    end else begin
      n_checks++;
      if (tx_q[0] !== 8'h4B || tx_q[1] !== 8'h45) begin
        n_fail++;
        $display("FAIL ack_seq: tx_data %h %h, required 4b 45", tx_q[0], tx_q[1]);
      end
    end
    tx_ready = 1'b0;
    exp_q.push_back(mk_word(7'h04, 9'h079));
    send_line("W04079");
    wait_cmd("ack_held");
    step();
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h4B || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_hold: tx_valid=%b tx_data=%h ovf=%b, required 1 4b 0", tx_valid, tx_data, ovf);
    end
    send_str("WX");
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h4B || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_drop: tx_valid=%b tx_data=%h ovf=%b, required 1 4b 1", tx_valid, tx_data, ovf);
    end
    send_byte(8'h0A);
    tx_q.delete();
    tx_ready = 1'b1;
    step();
    step();
    n_checks++;
    if (tx_q.size() != 1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_drain: %0d responses tx_valid=%b, required 1 and 0", tx_q.size(), tx_valid);
    end else begin
      n_checks++;
      if (tx_q[0] !== 8'h4B) begin
        n_fail++;
        $display("FAIL ack_drain_data: tx_data=%h, required 4b", tx_q[0]);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    rx_data   = '0;
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
`ifdef UART_CMD_ACK_EN
    tx_ready  = 1'b1;
`endif
    step();
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_timeout();
    test_hold();
    test_reset_mid();
`ifdef UART_CMD_ACK_EN
    test_ack();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d expected commands never seen", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
